// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals for alu_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_opcode;
  logic [8:0] req0_a;
  logic [8:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_opcode;
  logic [8:0] req1_a;
  logic [8:0] req1_b;
  logic       resp0_valid;
  logic       resp0_ready;
  logic       resp1_valid;
  logic       resp1_ready;
  logic [8:0] resp_data;
  logic       resp_err;
  logic [3:0] alu_opcode;
  logic [8:0] alu_a;
  logic [8:0] alu_b;
  logic [8:0] alu_out;
  logic       halted;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  resp0_ready, resp1_ready, alu_out,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
    output resp_data, resp_err, alu_opcode, alu_a, alu_b, halted
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output resp0_ready, resp1_ready, alu_out,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
    input  resp_data, resp_err, alu_opcode, alu_a, alu_b, halted
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// One operation in flight at a time: IDLE -> EXEC -> RESP -> IDLE; HALT
// freezes the block until reset.
module alu_arbiter (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXEC   = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [3:0] OP_NOP  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       last_grant_reg;  // 1 when req1 was granted most recently
  logic [3:0] op_reg;
  logic [8:0] a_reg;
  logic [8:0] b_reg;
  logic       id_reg;
  logic [8:0] result_reg;
  logic       err_reg;

  logic [1:0] req_valid;
  logic [1:0] resp_ready;
  logic [1:0] grant;
  logic [1:0] req_ready;
  logic [1:0] resp_valid;
  logic       accept;
  logic       accept_id;
  logic       resp_done;
  logic [3:0] opcode_sel;
  logic       op_undef;

  assign req_valid  = {bus.req1_valid, bus.req0_valid};
  assign resp_ready = {bus.resp1_ready, bus.resp0_ready};

  // Round-robin grant: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) begin
      grant = last_grant_reg ? 2'b01 : 2'b10;
    end else begin
      grant = req_valid;
    end
  end

  // Per-port ready/valid decode.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      localparam logic PORT_ID = 1'(gi);
      assign req_ready[gi]  = (state_reg == ST_IDLE) && grant[gi];
      assign resp_valid[gi] = (state_reg == ST_RESP) && (id_reg == PORT_ID);
    end
  endgenerate

  assign accept     = |(req_valid & req_ready);
  assign accept_id  = grant[1];
  assign resp_done  = |(resp_valid & resp_ready);
  assign opcode_sel = accept_id ? bus.req1_opcode : bus.req0_opcode;
  assign op_undef   = (op_reg >= 4'b1100) && (op_reg <= 4'b1110);

  // Next-state decode for the operation sequencer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = (opcode_sel == OP_HALT) ? ST_HALTED : ST_EXEC;
        end
      end
      ST_EXEC:   state_next = ST_RESP;
      ST_RESP: begin
        if (resp_done) begin
          state_next = ST_IDLE;
        end
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State, operand latch on accept and result capture at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= 1'b1;
      op_reg         <= OP_NOP;
      a_reg          <= '0;
      b_reg          <= '0;
      id_reg         <= 1'b0;
      result_reg     <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg         <= opcode_sel;
        a_reg          <= accept_id ? bus.req1_a : bus.req0_a;
        b_reg          <= accept_id ? bus.req1_b : bus.req0_b;
        id_reg         <= accept_id;
        last_grant_reg <= accept_id;
      end
      if (state_reg == ST_EXEC) begin
        // Undefined opcodes return zero with the error flag rather than ALU garbage.
        result_reg <= op_undef ? 9'd0 : bus.alu_out;
        err_reg    <= op_undef;
      end
    end
  end

  assign bus.req0_ready  = req_ready[0];
  assign bus.req1_ready  = req_ready[1];
  assign bus.resp0_valid = resp_valid[0];
  assign bus.resp1_valid = resp_valid[1];
  assign bus.resp_data   = result_reg;
  assign bus.resp_err    = err_reg && (state_reg == ST_RESP);
  assign bus.halted      = (state_reg == ST_HALTED);

  // The shared ALU only sees real operands during EXEC; otherwise it idles on NOP.
  assign bus.alu_opcode = (state_reg == ST_EXEC) ? op_reg : OP_NOP;
  assign bus.alu_a      = (state_reg == ST_EXEC) ? a_reg  : 9'd0;
  assign bus.alu_b      = (state_reg == ST_EXEC) ? b_reg  : 9'd0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU model.
module tb_alu_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU (opcode 1001 is MOV: pass a through).
  always_comb begin
    case (bus.alu_opcode)
      4'b0000: bus.alu_out = bus.alu_a & bus.alu_b;
      4'b0001: bus.alu_out = bus.alu_a | bus.alu_b;
      4'b0010: bus.alu_out = bus.alu_a ^ bus.alu_b;
      4'b0011: bus.alu_out = bus.alu_a + bus.alu_b;
      4'b0100: bus.alu_out = bus.alu_a - bus.alu_b;
      4'b1011: bus.alu_out = 9'd0;
      default: bus.alu_out = bus.alu_a;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] op, input logic [8:0] a, input logic [8:0] b);
    bus.req0_valid  = v;
    bus.req0_opcode = op;
    bus.req0_a      = a;
    bus.req0_b      = b;
  endtask

  task automatic drive1(input logic v, input logic [3:0] op, input logic [8:0] a, input logic [8:0] b);
    bus.req1_valid  = v;
    bus.req1_opcode = op;
    bus.req1_a      = a;
    bus.req1_b      = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    drive0(1'b0, 4'b1011, 9'd0, 9'd0);
    drive1(1'b0, 4'b1011, 9'd0, 9'd0);
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    step();
    step();

    // Reset state
    #1;
    check("rst_halted", 16'(bus.halted), 16'h0);
    check("rst_rvalid", 16'({bus.resp1_valid, bus.resp0_valid}), 16'h0);
    check("rst_data", 16'(bus.resp_data), 16'h000);
    check("rst_err", 16'(bus.resp_err), 16'h0);
    check("rst_aluop", 16'(bus.alu_opcode), 16'hB);
    check("rst_aluab", 16'({bus.alu_a, bus.alu_b}), 16'h0);
    reset = 1'b0;
    step();

    // ADD 3+4 from req0: accept T, EXEC T+1, response T+2
    drive0(1'b1, 4'b0011, 9'd3, 9'd4);
    #1;
    check("add_ready", 16'({bus.req1_ready, bus.req0_ready}), 16'h1);
    step();
    drive0(1'b0, 4'b0011, 9'd3, 9'd4);
    #1;
    check("add_exec_op", 16'(bus.alu_opcode), 16'h3);
    check("add_exec_ab", 16'({bus.alu_a, bus.alu_b}), 16'({9'd3, 9'd4}));
    check("add_exec_rv", 16'(bus.resp0_valid), 16'h0);
    step();
    #1;
    check("add_rvalid", 16'(bus.resp0_valid), 16'h1);
    check("add_data", 16'(bus.resp_data), 16'h007);
    check("add_err", 16'(bus.resp_err), 16'h0);
    check("add_resp_aluop", 16'(bus.alu_opcode), 16'hB);
    step();
    #1;
    check("add_done", 16'(bus.resp0_valid), 16'h0);

    // Round robin after reset: req0 first, then req1
    do_reset();
    drive0(1'b1, 4'b0000, 9'h00F, 9'h03C);
    drive1(1'b1, 4'b0100, 9'd5, 9'd7);
    #1;
    check("rr1_ready", 16'({bus.req1_ready, bus.req0_ready}), 16'h1);
    step();
    drive0(1'b0, 4'b0000, 9'h00F, 9'h03C);
    #1;
    check("rr1_exec_noready", 16'({bus.req1_ready, bus.req0_ready}), 16'h0);
    step();
    #1;
    check("rr1_resp", 16'({bus.resp1_valid, bus.resp0_valid}), 16'h1);
    check("rr1_data", 16'(bus.resp_data), 16'h00C);
    step();
    #1;
    check("rr2_ready", 16'({bus.req1_ready, bus.req0_ready}), 16'h2);
    step();
    drive1(1'b0, 4'b0100, 9'd5, 9'd7);
    step();
    #1;
    check("rr2_resp", 16'({bus.resp1_valid, bus.resp0_valid}), 16'h2);
    check("rr2_data", 16'(bus.resp_data), 16'h1FE);
    step();
    // Second simultaneous pair: req1 went last, so req0 wins again
    drive0(1'b1, 4'b0011, 9'd10, 9'd20);
    drive1(1'b1, 4'b0001, 9'h100, 9'h001);
    #1;
    check("rr3_ready", 16'({bus.req1_ready, bus.req0_ready}), 16'h1);
    step();
    drive0(1'b0, 4'b0011, 9'd10, 9'd20);
    step();
    #1;
    check("rr3_data", 16'(bus.resp_data), 16'h01E);
    step();

    // req1 now wins the tie (req0 went last); its response is held 3 cycles
    drive0(1'b1, 4'b0010, 9'h0F0, 9'h0FF);
    bus.resp1_ready = 1'b0;
    #1;
    check("hold_ready", 16'({bus.req1_ready, bus.req0_ready}), 16'h2);
    step();
    drive1(1'b0, 4'b0001, 9'h100, 9'h001);
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_rvalid", 16'(bus.resp1_valid), 16'h1);
      check("hold_data", 16'(bus.resp_data), 16'h101);
      check("hold_noready", 16'(bus.req0_ready), 16'h0);
      step();
    end
    bus.resp1_ready = 1'b1;
    #1;
    check("hold_last", 16'(bus.resp1_valid), 16'h1);
    step();
    #1;
    check("hold_next_ready", 16'({bus.req1_ready, bus.req0_ready}), 16'h1);
    step();
    drive0(1'b0, 4'b0010, 9'h0F0, 9'h0FF);
    step();
    #1;
    check("xor_data", 16'(bus.resp_data), 16'h00F);
    step();

    // Undefined opcode from req1
    drive1(1'b1, 4'b1101, 9'd5, 9'd6);
    step();
    drive1(1'b0, 4'b1101, 9'd5, 9'd6);
    step();
    #1;
    check("undef_rvalid", 16'({bus.resp1_valid, bus.resp0_valid}), 16'h2);
    check("undef_data", 16'(bus.resp_data), 16'h000);
    check("undef_err", 16'(bus.resp_err), 16'h1);
    step();
    #1;
    check("undef_err_clr", 16'(bus.resp_err), 16'h0);

    // 9-bit wrap: 0x1FF + 2 = 0x001
    drive0(1'b1, 4'b0011, 9'h1FF, 9'h002);
    step();
    drive0(1'b0, 4'b0011, 9'h1FF, 9'h002);
    step();
    #1;
    check("wrap_data", 16'(bus.resp_data), 16'h001);
    check("wrap_err", 16'(bus.resp_err), 16'h0);
    step();

    // HALT freezes the block
    drive0(1'b1, 4'b1111, 9'd0, 9'd0);
    #1;
    check("halt_ready", 16'(bus.req0_ready), 16'h1);
    step();
    drive0(1'b1, 4'b0011, 9'd1, 9'd1);
    drive1(1'b1, 4'b0011, 9'd2, 9'd2);
    #1;
    check("halt_flag", 16'(bus.halted), 16'h1);
    check("halt_aluop", 16'(bus.alu_opcode), 16'hB);
    for (int i = 0; i < 3; i++) begin
      check("halt_ready_lo", 16'({bus.req1_ready, bus.req0_ready}), 16'h0);
      check("halt_rvalid_lo", 16'({bus.resp1_valid, bus.resp0_valid}), 16'h0);
      step();
      #1;
    end
    drive1(1'b0, 4'b0011, 9'd2, 9'd2);
    do_reset();
    #1;
    check("halt_cleared", 16'(bus.halted), 16'h0);
    step();
    drive0(1'b0, 4'b0011, 9'd1, 9'd1);
    step();
    #1;
    check("post_halt_data", 16'(bus.resp_data), 16'h002);
    check("post_halt_rv", 16'(bus.resp0_valid), 16'h1);
    step();

    // Reset during EXEC aborts the operation
    drive0(1'b1, 4'b1001, 9'h155, 9'd0);
    step();
    drive0(1'b0, 4'b1001, 9'h155, 9'd0);
    #1;
    check("abort_exec_a", 16'(bus.alu_a), 16'h155);
    reset = 1'b1;
    step();
    #1;
    check("abort_rvalid", 16'(bus.resp0_valid), 16'h0);
    check("abort_data", 16'(bus.resp_data), 16'h000);
    check("abort_aluop", 16'(bus.alu_opcode), 16'hB);
    check("abort_alua", 16'(bus.alu_a), 16'h000);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check("abort_no_resp", 16'({bus.resp1_valid, bus.resp0_valid}), 16'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
